// File: rtl/bus_select_arbiter.sv
// Two-source arbiter feeding a one-deep registered output stage; sel drives a downstream 2:1 bus mux.
// Define BUS_SELECT_ROUND_ROBIN_EN for round-robin contention; otherwise in_1 has fixed priority.
module bus_select_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_1,
  input  logic             in_1_valid,
  output logic             in_1_ready,
  input  logic [WIDTH-1:0] in_2,
  input  logic             in_2_valid,
  output logic             in_2_ready,
  output logic             sel,
  output logic [WIDTH-1:0] out_1,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_q;
  logic             last_grant;  // 0 = in_1 won last, 1 = in_2 won last
  logic [WIDTH-1:0] data_q;
  logic             both_valid;
  logic             can_accept;
  logic             xfer;

  assign both_valid = in_1_valid & in_2_valid;

`ifdef BUS_SELECT_ROUND_ROBIN_EN
  assign sel = both_valid ? ~last_grant : (in_2_valid & ~in_1_valid);
`else
  logic unused_last_grant;
  assign sel               = in_2_valid & ~in_1_valid;
  assign unused_last_grant = last_grant;
`endif

  // Handshake: a word moves when valid and ready are both 1 in the same cycle;
  // ready is offered only to the granted, valid source while the output can accept.
  assign out_valid  = (state_q == FULL);
  assign can_accept = ~out_valid | out_ready;
  assign in_1_ready = ~reset & can_accept & in_1_valid & ~sel;
  assign in_2_ready = ~reset & can_accept & in_2_valid & sel;
  assign xfer       = in_1_ready | in_2_ready;
  assign out_1      = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      data_q     <= '0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      state_q    <= FULL;
      data_q     <= sel ? in_2 : in_1;
      last_grant <= sel;
    end else if ((state_q == FULL) && out_ready) begin
      state_q <= EMPTY;
    end
  end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Self-checking bench for bus_select_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of grant, handshake and output register.
module tb_bus_select_arbiter;

  localparam int WIDTH = 4;
`ifdef BUS_SELECT_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_1, in_2, out_1;
  logic             in_1_valid, in_1_ready, in_2_valid, in_2_ready;
  logic             sel, out_valid, out_ready;

  int tests_run = 0;
  int tests_failed = 0;

  // model state: holding flag, held word, index (1 or 2) of last winner
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_last;
  logic [WIDTH-1:0] exp_q[$];

  bus_select_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_1(in_1), .in_1_valid(in_1_valid), .in_1_ready(in_1_ready),
    .in_2(in_2), .in_2_valid(in_2_valid), .in_2_ready(in_2_ready),
    .sel(sel), .out_1(out_1), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int pick(input bit v1, input bit v2);
    if (v1 && v2) return RR ? ((m_last == 1) ? 2 : 1) : 1;
    if (v1) return 1;
    if (v2) return 2;
    return 0;
  endfunction

  // Drives one cycle, checks everything visible against the model, advances the model.
  task automatic cycle(input bit r, input bit v1, input logic [WIDTH-1:0] d1,
                       input bit v2, input logic [WIDTH-1:0] d2, input bit ordy,
                       output logic o_sel, output logic o_r1, output logic o_r2);
    int  w;
    bit  xfer;
    reset = r; in_1_valid = v1; in_1 = d1; in_2_valid = v2; in_2 = d2; out_ready = ordy;
    @(negedge clk);
    w    = pick(v1, v2);
    xfer = !r && (w != 0) && (!m_valid || ordy);
    o_sel = sel; o_r1 = in_1_ready; o_r2 = in_2_ready;
    tests_run++;
    if (sel !== (w == 2)) begin
      tests_failed++; $display("FAIL sel: got %b want %b @%0t", sel, (w == 2), $time);
    end
    tests_run++;
    if (in_1_ready !== (xfer && w == 1)) begin
      tests_failed++; $display("FAIL in_1_ready: got %b want %b @%0t", in_1_ready, (xfer && w == 1), $time);
    end
    tests_run++;
    if (in_2_ready !== (xfer && w == 2)) begin
      tests_failed++; $display("FAIL in_2_ready: got %b want %b @%0t", in_2_ready, (xfer && w == 2), $time);
    end
    tests_run++;
    if (out_valid !== m_valid) begin
      tests_failed++; $display("FAIL out_valid: got %b want %b @%0t", out_valid, m_valid, $time);
    end
    if (m_valid) begin
      tests_run++;
      if (out_1 !== m_data) begin
        tests_failed++; $display("FAIL out_1: got %h want %h @%0t", out_1, m_data, $time);
      end
    end
    if (!r && m_valid && ordy) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++; $display("FAIL scoreboard: drain with empty queue @%0t", $time);
      end else if (out_1 !== exp_q[0]) begin
        tests_failed++; $display("FAIL scoreboard: got %h want %h @%0t", out_1, exp_q[0], $time);
        void'(exp_q.pop_front());
      end else void'(exp_q.pop_front());
    end
    if (r) begin
      m_valid = 0; m_data = '0; m_last = 2; exp_q.delete();
    end else if (xfer) begin
      m_data = (w == 1) ? d1 : d2; m_valid = 1; m_last = w; exp_q.push_back(m_data);
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_reset(input int n);
    logic s, a, b;
    for (int i = 0; i < n; i++) cycle(1, 0, '0, 0, '0, 0, s, a, b);
  endtask

  task automatic test_reset();
    logic s, a, b;
    idle_reset(2);
    tests_run++;
    if (out_valid !== 1'b0 || out_1 !== 4'h0) begin
      tests_failed++; $display("FAIL reset_state: valid=%b out_1=%h want 0/0", out_valid, out_1);
    end
    cycle(1, 1, 4'h7, 1, 4'h8, 1, s, a, b);
    tests_run++;
    if (a !== 1'b0 || b !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ready: r1=%b r2=%b want 0/0", a, b);
    end
  endtask

  task automatic test_single();
    logic s, a, b;
    idle_reset(1);
    cycle(0, 1, 4'hA, 0, 4'h0, 1, s, a, b);
    tests_run++;
    if (a !== 1'b1 || s !== 1'b0) begin
      tests_failed++; $display("FAIL single_accept: r1=%b sel=%b want 1/0", a, s);
    end
    tests_run++;
    if (out_1 !== 4'hA || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL single_out: out_1=%h valid=%b want a/1", out_1, out_valid);
    end
    cycle(0, 0, 4'h0, 0, 4'h0, 1, s, a, b);
  endtask

  task automatic test_contention();
    logic s, a, b;
    logic [WIDTH-1:0] seq_rr [4];
    logic [WIDTH-1:0] seq_fp [4];
    logic [WIDTH-1:0] want;
    seq_rr = '{4'h3, 4'hC, 4'h3, 4'hC};
    seq_fp = '{4'h3, 4'h3, 4'h3, 4'h3};
    idle_reset(1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 4'h3, 1, 4'hC, 1, s, a, b);
      want = RR ? seq_rr[i] : seq_fp[i];
      tests_run++;
      if (out_1 !== want) begin
        tests_failed++; $display("FAIL contention_seq[%0d]: got %h want %h", i, out_1, want);
      end
      if (!RR) begin
        tests_run++;
        if (b !== 1'b0) begin
          tests_failed++; $display("FAIL contention_in2_ready: got %b want 0", b);
        end
      end
    end
    cycle(0, 0, 4'h0, 0, 4'h0, 1, s, a, b);
  endtask

  task automatic test_backpressure();
    logic s, a, b;
    idle_reset(1);
    cycle(0, 1, 4'h5, 0, 4'h0, 0, s, a, b);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 4'h0, 1, 4'(9 + i), 0, s, a, b);
      tests_run++;
      if (b !== 1'b0 || out_1 !== 4'h5) begin
        tests_failed++; $display("FAIL stall[%0d]: r2=%b out_1=%h want 0/5", i, b, out_1);
      end
    end
    cycle(0, 0, 4'h0, 1, 4'hE, 1, s, a, b);
    tests_run++;
    if (b !== 1'b1 || out_1 !== 4'hE || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL release: r2=%b out_1=%h valid=%b want 1/e/1", b, out_1, out_valid);
    end
  endtask

  task automatic test_drain();
    logic s, a, b;
    cycle(0, 0, 4'h0, 0, 4'h0, 1, s, a, b);
    tests_run++;
    if (out_valid !== 1'b0 || s !== 1'b0 || out_1 !== 4'hE) begin
      tests_failed++; $display("FAIL drain: valid=%b sel=%b out_1=%h want 0/0/e", out_valid, s, out_1);
    end
  endtask

  task automatic test_mid_reset();
    logic s, a, b;
    cycle(0, 0, 4'h0, 1, 4'h6, 0, s, a, b);
    cycle(1, 1, 4'h1, 1, 4'h2, 1, s, a, b);
    tests_run++;
    if (a !== 1'b0 || b !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset: r1=%b r2=%b valid=%b want 0/0/0", a, b, out_valid);
    end
    cycle(0, 1, 4'h1, 1, 4'h2, 1, s, a, b);
    tests_run++;
    if (a !== 1'b1 || out_1 !== 4'h1) begin
      tests_failed++; $display("FAIL post_reset_grant: r1=%b out_1=%h want 1/1", a, out_1);
    end
  endtask

  task automatic test_random();
    logic s, a, b;
    idle_reset(1);
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1), WIDTH'($urandom),
            $urandom_range(0, 1), WIDTH'($urandom), ($urandom_range(0, 3) != 0), s, a, b);
  endtask

  initial begin
    m_valid = 0; m_data = '0; m_last = 2;
    reset = 1; in_1 = '0; in_2 = '0; in_1_valid = 0; in_2_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_drain();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
